// File: rtl/sync_fifo_buffer.sv
// Parametrised single-clock FIFO with occupancy level, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo_buffer #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_in_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd_en,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_out_valid,
   output logic                       buffer_empty,
   output logic                       buffer_full,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_empty;
   logic             r_full;
   logic             r_almost_full;
   logic             r_almost_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_rd_acc;
   logic             w_wr_acc;
   logic [LW-1:0]    w_level_next;

   // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
   assign w_rd_acc = rd_en & ~r_empty;
   assign w_wr_acc = data_in_en & (~r_full | w_rd_acc);

   always_comb begin
      w_level_next = r_level;
      if (w_wr_acc && !w_rd_acc) begin
         w_level_next = r_level + LW'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
         w_level_next = r_level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_empty        <= 1'b1;
         r_full         <= 1'b0;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level        <= w_level_next;
         r_empty        <= (w_level_next == '0);
         r_full         <= (w_level_next == LW'(DEPTH));
         r_almost_full  <= (w_level_next >= LW'(AF_THRESH));
         r_almost_empty <= (w_level_next <= LW'(AE_THRESH));
         // A new error event in the same cycle as clr_err keeps the flag set.
         r_overflow     <= (data_in_en & ~w_wr_acc) | (r_overflow & ~clr_err);
         r_underflow    <= (rd_en & r_empty) | (r_underflow & ~clr_err);
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented directly; an empty FIFO shows zero so reset leaves data_out cleared.
   assign data_out       = r_empty ? '0 : r_mem[r_rd_ptr];
   assign data_out_valid = ~r_empty;
`else
   logic [WIDTH-1:0] r_data_out;
   logic             r_data_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out       <= '0;
         r_data_out_valid <= 1'b0;
      end else begin
         r_data_out_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
      end
   end

   assign data_out       = r_data_out;
   assign data_out_valid = r_data_out_valid;
`endif

   assign buffer_empty = r_empty;
   assign buffer_full  = r_full;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign level        = r_level;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed and random stimulus for sync_fifo_buffer, checked against a queue-based reference model.
// Works in both read modes (SYNC_FIFO_FWFT_EN defined or not).
module tb_sync_fifo_buffer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int AF_T  = DEPTH - 2;
   localparam int AE_T  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             data_in_en = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             rd_en = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_out_valid;
   logic             buffer_empty;
   logic             buffer_full;
   logic             almost_full;
   logic             almost_empty;
   logic [$clog2(DEPTH):0] level;
   logic             overflow;
   logic             underflow;

   sync_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T)) dut (
      .clk(clk), .rst(rst), .data_in_en(data_in_en), .data_in(data_in), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(data_out), .data_out_valid(data_out_valid),
      .buffer_empty(buffer_empty), .buffer_full(buffer_full), .almost_full(almost_full),
      .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout  = '0;
   logic             m_valid = 1'b0;
   logic             m_ovf   = 1'b0;
   logic             m_udf   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
      m_valid = (n != 0);
      m_dout  = (n != 0) ? q[0] : '0;
`endif
      check({tag, ".level"}, 32'(level), 32'(n));
      check({tag, ".empty"}, 32'(buffer_empty), 32'(n == 0));
      check({tag, ".full"}, 32'(buffer_full), 32'(n == DEPTH));
      check({tag, ".afull"}, 32'(almost_full), 32'(n >= AF_T));
      check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE_T));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
      check({tag, ".valid"}, 32'(data_out_valid), 32'(m_valid));
      check({tag, ".dout"}, 32'(data_out), 32'(m_dout));
      $display("step %-8s we=%0d din=%04h re=%0d clr=%0d rst=%0d -> level=%0d dout=%04h v=%0d ovf=%0d udf=%0d",
               tag, data_in_en, data_in, rd_en, clr_err, rst, level, data_out, data_out_valid,
               overflow, underflow);
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input string tag, input logic r, input logic we, input logic [WIDTH-1:0] din,
                       input logic re, input logic clr);
      bit rd_ok, wr_ok;
      logic [WIDTH-1:0] popped;
      rst = r; data_in_en = we; data_in = din; rd_en = re; clr_err = clr;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         rd_ok = re && (q.size() != 0);
         wr_ok = we && ((q.size() < DEPTH) || rd_ok);
         m_ovf = (we && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_udf = (re && q.size() == 0) ? 1'b1 : (clr ? 1'b0 : m_udf);
         m_valid = 1'b0;
         if (rd_ok) begin
            popped  = q.pop_front();
            m_dout  = popped;
            m_valid = 1'b1;
         end
         if (wr_ok) q.push_back(din);
      end
      rst = 1'b0; data_in_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      step("reset", 1, 0, '0, 0, 0);

      for (int i = 1; i <= 8; i++) step("fill", 0, 1, WIDTH'(i), 0, 0);
      step("ovfwr", 0, 1, 16'h0009, 0, 0);
      for (int i = 0; i < 8; i++) step("drain", 0, 0, '0, 1, 0);

      step("udf", 0, 0, '0, 1, 0);
      step("clrerr", 0, 0, '0, 0, 1);
      step("rwempty", 0, 1, 16'h1234, 1, 0);
      step("clrerr2", 0, 0, '0, 0, 1);

      while (q.size() < DEPTH) step("refill", 0, 1, WIDTH'($urandom), 0, 0);
      for (int i = 0; i < 20; i++) step("rwfull", 0, 1, WIDTH'($urandom), 1, 0);
      for (int i = 0; i < 3; i++) step("pop3", 0, 0, '0, 1, 0);
      step("rst5", 1, 0, '0, 0, 0);

      step("beef", 0, 1, 16'hBEEF, 0, 0);
      step("beefrd", 0, 0, '0, 1, 0);
      step("setclr", 0, 0, '0, 1, 1);

      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), WIDTH'($urandom),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
